// File: rtl/wb_initiator_pkg.sv
// Shared types and default widths for the Wishbone classic initiator.
package wb_initiator_pkg;

   localparam int unsigned DEF_WORD_SIZE    = 32;
   localparam int unsigned DEF_WHISBONE_ADR = 32;
   localparam int unsigned DEF_COUNTERSIZE  = 32;
   localparam int unsigned TIMER_W          = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/wbm_timeout_timer.sv
// Counts bus cycles spent waiting for ack; expired_o flags the last allowed cycle.
module wbm_timeout_timer
   import wb_initiator_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   logic [TIMER_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = cnt_q + TIMER_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding request/response to Wishbone classic master bridge with ack timeout.
module wb_initiator
   import wb_initiator_pkg::*;
#(
   parameter int unsigned WORD_SIZE      = DEF_WORD_SIZE,
   parameter int unsigned WHISBONE_ADR   = DEF_WHISBONE_ADR,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned COUNTERSIZE    = DEF_COUNTERSIZE
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_we_i,
   input  logic [3:0]              req_sel_i,
   input  logic [WHISBONE_ADR-1:0] req_adr_i,
   input  logic [WORD_SIZE-1:0]    req_dat_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [WORD_SIZE-1:0]    rsp_dat_o,
   output logic                    rsp_err_o,
   output logic                    wbm_cyc_o,
   output logic                    wbm_stb_o,
   output logic                    wbm_we_o,
   output logic [3:0]              wbm_sel_o,
   output logic [WHISBONE_ADR-1:0] wbm_adr_o,
   output logic [WORD_SIZE-1:0]    wbm_dat_o,
   input  logic [WORD_SIZE-1:0]    wbm_dat_i,
   input  logic                    wbm_ack_i,
   output logic                    busy_o,
   output logic [COUNTERSIZE-1:0]  txn_count_o,
   output logic                    protocol_err_o
);

   state_e                  state_q, state_d;
   logic                    cyc_q, cyc_d;
   logic                    we_q, we_d;
   logic [3:0]              sel_q, sel_d;
   logic [WHISBONE_ADR-1:0] adr_q, adr_d;
   logic [WORD_SIZE-1:0]    dat_q, dat_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    rsp_err_q, rsp_err_d;
   logic [WORD_SIZE-1:0]    rsp_dat_q, rsp_dat_d;
   logic [COUNTERSIZE-1:0]  txn_q, txn_d;
   logic                    perr_q, perr_d;
   logic                    tmr_clear, tmr_en, tmr_expired;

   wbm_timeout_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (tmr_clear),
      .enable_i (tmr_en),
      .expired_o(tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_dat_d   = rsp_dat_q;
      txn_d       = txn_q;
      perr_d      = perr_q;
      tmr_clear   = 1'b0;
      tmr_en      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (wbm_ack_i) perr_d = 1'b1;
            if (req_valid_i) begin
               we_d      = req_we_i;
               sel_d     = req_sel_i;
               adr_d     = req_adr_i;
               dat_d     = req_we_i ? req_dat_i : '0;
               cyc_d     = 1'b1;
               tmr_clear = 1'b1;
               state_d   = ST_BUS;
            end
         end
         ST_BUS: begin
            // Ack is tested before expiry so a coincident ack completes normally.
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_dat_d   = we_q ? '0 : wbm_dat_i;
               txn_d       = txn_q + COUNTERSIZE'(1);
               state_d     = ST_RESP;
            end else if (tmr_expired) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_dat_d   = '0;
               state_d     = ST_RESP;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_RESP: begin
            if (wbm_ack_i) perr_d = 1'b1;
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= '0;
         txn_q       <= '0;
         perr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_dat_q   <= rsp_dat_d;
         txn_q       <= txn_d;
         perr_q      <= perr_d;
      end
   end

   assign req_ready_o    = (state_q == ST_IDLE);
   assign busy_o         = (state_q != ST_IDLE);
   assign wbm_cyc_o      = cyc_q;
   assign wbm_stb_o      = cyc_q;
   assign wbm_we_o       = we_q;
   assign wbm_sel_o      = sel_q;
   assign wbm_adr_o      = adr_q;
   assign wbm_dat_o      = dat_q;
   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_err_o      = rsp_err_q;
   assign rsp_dat_o      = rsp_dat_q;
   assign txn_count_o    = txn_q;
   assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Scenario bench for wb_initiator with a response scoreboard queue.
module tb_wb_initiator;

   localparam int unsigned TO = 16;

   typedef struct packed {
      logic [31:0] dat;
      logic        err;
   } rsp_t;

   logic        clk_i, rst_ni;
   logic        req_valid_i, req_ready_o, req_we_i;
   logic [3:0]  req_sel_i;
   logic [31:0] req_adr_i, req_dat_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
   logic [31:0] rsp_dat_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic        wbm_ack_i, busy_o, protocol_err_o;
   logic [31:0] txn_count_o;

   rsp_t        exp_q[$];
   int unsigned n_run, n_fail;
   logic [31:0] exp_cnt;

   wb_initiator #(
      .WORD_SIZE     (32),
      .WHISBONE_ADR  (32),
      .TIMEOUT_CYCLES(TO),
      .COUNTERSIZE   (32)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_we_i      (req_we_i),
      .req_sel_i     (req_sel_i),
      .req_adr_i     (req_adr_i),
      .req_dat_i     (req_dat_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_dat_o     (rsp_dat_o),
      .rsp_err_o     (rsp_err_o),
      .wbm_cyc_o     (wbm_cyc_o),
      .wbm_stb_o     (wbm_stb_o),
      .wbm_we_o      (wbm_we_o),
      .wbm_sel_o     (wbm_sel_o),
      .wbm_adr_o     (wbm_adr_o),
      .wbm_dat_o     (wbm_dat_o),
      .wbm_dat_i     (wbm_dat_i),
      .wbm_ack_i     (wbm_ack_i),
      .busy_o        (busy_o),
      .txn_count_o   (txn_count_o),
      .protocol_err_o(protocol_err_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic rsp_t mk(input logic [31:0] d, input logic e);
      rsp_t r;
      r.dat = d;
      r.err = e;
      return r;
   endfunction

   // Present a command and wait (bounded) for the accepting edge; returns #1 after it.
   task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, output logic ok);
      ok = 1'b0;
      req_valid_i = 1'b1; req_we_i = we; req_sel_i = sel; req_adr_i = adr; req_dat_i = dat;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (req_ready_o) ok = 1'b1;
         @(posedge clk_i); #1;
      end
      req_valid_i = 1'b0;
   endtask

   // Slave model: acks on bus cycle ack_at (0 = never); reports cycles cyc was high.
   task automatic run_bus(input int unsigned ack_at, input logic [31:0] rdata,
                          output int unsigned hi, output logic stable);
      logic [31:0] adr0, dat0;
      logic [3:0]  sel0;
      logic        we0;
      hi = 0; stable = 1'b1;
      adr0 = wbm_adr_o; dat0 = wbm_dat_o; sel0 = wbm_sel_o; we0 = wbm_we_o;
      for (int unsigned c = 1; c <= 40; c++) begin
         if (!wbm_cyc_o) break;
         hi++;
         if (wbm_stb_o !== 1'b1 || wbm_adr_o !== adr0 || wbm_dat_o !== dat0 ||
             wbm_sel_o !== sel0 || wbm_we_o !== we0) stable = 1'b0;
         if (c == ack_at) begin
            wbm_ack_i = 1'b1; wbm_dat_i = rdata;
         end
         @(posedge clk_i); #1;
         wbm_ack_i = 1'b0; wbm_dat_i = '0;
      end
   endtask

   task automatic collect(output logic got, output logic [31:0] dat, output logic err);
      got = 1'b0; dat = '0; err = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (rsp_valid_o) got = 1'b1;
         else begin @(posedge clk_i); #1; end
      end
      if (got) begin
         dat = rsp_dat_o; err = rsp_err_o;
         rsp_ready_i = 1'b1;
         @(posedge clk_i); #1;
         rsp_ready_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b1;
      #1 rst_ni = 1'b0;
      #2;
      n_run++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid_o, rsp_err_o, busy_o, protocol_err_o} !== 7'b0 ||
          wbm_sel_o !== 4'h0 || wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 ||
          rsp_dat_o !== 32'h0 || txn_count_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_values: cyc=%b stb=%b rsp_valid=%b busy=%b perr=%b txn=%h adr=%h required all zero",
                  wbm_cyc_o, wbm_stb_o, rsp_valid_o, busy_o, protocol_err_o, txn_count_o, wbm_adr_o);
      end
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(posedge clk_i); #1;
      n_run++;
      if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: req_ready=%b busy=%b required 1/0", req_ready_o, busy_o);
      end
   endtask

   task automatic test_write();
      logic ok, got, stable, err;
      logic [31:0] dat;
      int unsigned hi;
      rsp_t e;
      issue(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, ok);
      exp_q.push_back(mk(32'h0, 1'b0));
      n_run++;
      if (ok !== 1'b1 || wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1 ||
          wbm_adr_o !== 32'h3000_0004 || wbm_dat_o !== 32'hDEAD_BEEF || wbm_sel_o !== 4'hF) begin
         n_fail++;
         $display("FAIL write_fields: ok=%b cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h required 1/1/1/1/30000004/deadbeef/f",
                  ok, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
      end
      run_bus(3, 32'hFFFF_FFFF, hi, stable);
      n_run++;
      if (hi !== 3 || stable !== 1'b1) begin
         n_fail++;
         $display("FAIL write_bus_len: cycles=%0d stable=%b required 3/1", hi, stable);
      end
      collect(got, dat, err);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(32'hX, 1'bX);
      exp_cnt++;
      n_run++;
      if (got !== 1'b1 || dat !== e.dat || err !== e.err) begin
         n_fail++;
         $display("FAIL write_rsp: got=%b dat=%h err=%b required 1/%h/%b", got, dat, err, e.dat, e.err);
      end
      n_run++;
      if (txn_count_o !== exp_cnt || req_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL write_count: txn=%0d ready=%b required %0d/1", txn_count_o, req_ready_o, exp_cnt);
      end
   endtask

   task automatic test_read();
      logic ok, got, stable, err;
      logic [31:0] dat;
      int unsigned hi;
      rsp_t e;
      issue(1'b0, 4'h3, 32'h3000_0008, 32'hAAAA_5555, ok);
      exp_q.push_back(mk(32'h1234_5678, 1'b0));
      n_run++;
      if (ok !== 1'b1 || wbm_cyc_o !== 1'b1 || wbm_we_o !== 1'b0 || wbm_dat_o !== 32'h0 ||
          wbm_adr_o !== 32'h3000_0008 || wbm_sel_o !== 4'h3) begin
         n_fail++;
         $display("FAIL read_fields: cyc=%b we=%b dat=%h adr=%h sel=%h required 1/0/0/30000008/3",
                  wbm_cyc_o, wbm_we_o, wbm_dat_o, wbm_adr_o, wbm_sel_o);
      end
      run_bus(2, 32'h1234_5678, hi, stable);
      n_run++;
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h1234_5678 || wbm_cyc_o !== 1'b0 || hi !== 2) begin
         n_fail++;
         $display("FAIL read_after_ack: rsp_valid=%b rsp_dat=%h cyc=%b cycles=%0d required 1/12345678/0/2",
                  rsp_valid_o, rsp_dat_o, wbm_cyc_o, hi);
      end
      collect(got, dat, err);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(32'hX, 1'bX);
      exp_cnt++;
      n_run++;
      if (got !== 1'b1 || dat !== e.dat || err !== e.err || txn_count_o !== exp_cnt) begin
         n_fail++;
         $display("FAIL read_rsp: got=%b dat=%h err=%b txn=%0d required 1/%h/%b/%0d",
                  got, dat, err, txn_count_o, e.dat, e.err, exp_cnt);
      end
   endtask

   task automatic test_timeout();
      logic ok, got, stable, err;
      logic [31:0] dat;
      int unsigned hi;
      rsp_t e;
      issue(1'b0, 4'hF, 32'h3000_000C, 32'h0, ok);
      exp_q.push_back(mk(32'h0, 1'b1));
      run_bus(0, 32'h0, hi, stable);
      n_run++;
      if (ok !== 1'b1 || hi !== TO || stable !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_len: ok=%b cycles=%0d stable=%b required 1/%0d/1", ok, hi, stable, TO);
      end
      collect(got, dat, err);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(32'hX, 1'bX);
      n_run++;
      if (got !== 1'b1 || dat !== e.dat || err !== e.err || txn_count_o !== exp_cnt) begin
         n_fail++;
         $display("FAIL timeout_rsp: got=%b dat=%h err=%b txn=%0d required 1/%h/%b/%0d",
                  got, dat, err, txn_count_o, e.dat, e.err, exp_cnt);
      end
   endtask

   task automatic test_ack_at_timeout();
      logic ok, got, stable, err;
      logic [31:0] dat;
      int unsigned hi;
      rsp_t e;
      issue(1'b0, 4'hC, 32'h3000_0020, 32'h0, ok);
      exp_q.push_back(mk(32'h0BAD_F00D, 1'b0));
      run_bus(TO, 32'h0BAD_F00D, hi, stable);
      n_run++;
      if (ok !== 1'b1 || hi !== TO) begin
         n_fail++;
         $display("FAIL edge_ack_len: ok=%b cycles=%0d required 1/%0d", ok, hi, TO);
      end
      collect(got, dat, err);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(32'hX, 1'bX);
      exp_cnt++;
      n_run++;
      if (got !== 1'b1 || dat !== e.dat || err !== e.err || txn_count_o !== exp_cnt) begin
         n_fail++;
         $display("FAIL edge_ack_rsp: got=%b dat=%h err=%b txn=%0d required 1/%h/%b/%0d",
                  got, dat, err, txn_count_o, e.dat, e.err, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic ok, got, stable, err, hold_ok;
      logic [31:0] dat;
      int unsigned hi;
      rsp_t e;
      issue(1'b0, 4'hF, 32'h3000_0030, 32'h0, ok);
      exp_q.push_back(mk(32'hCAFE_0001, 1'b0));
      run_bus(2, 32'hCAFE_0001, hi, stable);
      exp_cnt++;
      req_valid_i = 1'b1; req_we_i = 1'b1; req_sel_i = 4'h5;
      req_adr_i = 32'h3000_0010; req_dat_i = 32'h5555_AAAA;
      hold_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'hCAFE_0001 || rsp_err_o !== 1'b0 ||
             req_ready_o !== 1'b0 || wbm_cyc_o !== 1'b0) hold_ok = 1'b0;
         @(posedge clk_i); #1;
      end
      n_run++;
      if (hold_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL backpressure_hold: rsp_valid=%b rsp_dat=%h ready=%b cyc=%b required 1/cafe0001/0/0",
                  rsp_valid_o, rsp_dat_o, req_ready_o, wbm_cyc_o);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(32'hX, 1'bX);
      n_run++;
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== e.dat || rsp_err_o !== e.err) begin
         n_fail++;
         $display("FAIL backpressure_rsp: valid=%b dat=%h err=%b required 1/%h/%b",
                  rsp_valid_o, rsp_dat_o, rsp_err_o, e.dat, e.err);
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b0;
      n_run++;
      if (req_ready_o !== 1'b1 || wbm_cyc_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL second_not_early: ready=%b cyc=%b rsp_valid=%b required 1/0/0",
                  req_ready_o, wbm_cyc_o, rsp_valid_o);
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      exp_q.push_back(mk(32'h0, 1'b0));
      n_run++;
      if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h3000_0010 || wbm_we_o !== 1'b1 ||
          wbm_dat_o !== 32'h5555_AAAA || wbm_sel_o !== 4'h5) begin
         n_fail++;
         $display("FAIL second_start: cyc=%b adr=%h we=%b dat=%h sel=%h required 1/30000010/1/5555aaaa/5",
                  wbm_cyc_o, wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o);
      end
      run_bus(1, 32'h0, hi, stable);
      collect(got, dat, err);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(32'hX, 1'bX);
      exp_cnt++;
      n_run++;
      if (got !== 1'b1 || dat !== e.dat || err !== e.err || txn_count_o !== exp_cnt ||
          protocol_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL second_rsp: got=%b dat=%h err=%b txn=%0d perr=%b required 1/%h/%b/%0d/0",
                  got, dat, err, txn_count_o, protocol_err_o, e.dat, e.err, exp_cnt);
      end
   endtask

   task automatic test_reset_mid_bus();
      logic ok, got, stable, err, quiet;
      logic [31:0] dat;
      int unsigned hi;
      rsp_t e;
      issue(1'b1, 4'hF, 32'h3000_0040, 32'h1111_2222, ok);
      repeat (3) begin @(posedge clk_i); #1; end
      n_run++;
      if (ok !== 1'b1 || wbm_cyc_o !== 1'b1) begin
         n_fail++;
         $display("FAIL midbus_pre: ok=%b cyc=%b required 1/1", ok, wbm_cyc_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      exp_cnt = '0;
      n_run++;
      if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 ||
          rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || txn_count_o !== 32'h0 || protocol_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midbus_reset: cyc=%b stb=%b adr=%h rsp_valid=%b busy=%b txn=%0d perr=%b required all zero",
                  wbm_cyc_o, wbm_stb_o, wbm_adr_o, rsp_valid_o, busy_o, txn_count_o, protocol_err_o);
      end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid_o !== 1'b0 || wbm_cyc_o !== 1'b0) quiet = 1'b0;
         @(posedge clk_i); #1;
      end
      wbm_ack_i = 1'b1; wbm_dat_i = 32'h9999_9999;
      @(posedge clk_i); #1;
      wbm_ack_i = 1'b0; wbm_dat_i = '0;
      n_run++;
      if (quiet !== 1'b1 || protocol_err_o !== 1'b1 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0 ||
          rsp_dat_o !== 32'h0) begin
         n_fail++;
         $display("FAIL stray_ack: quiet=%b perr=%b rsp_valid=%b busy=%b rsp_dat=%h required 1/1/0/0/0",
                  quiet, protocol_err_o, rsp_valid_o, busy_o, rsp_dat_o);
      end
      issue(1'b1, 4'hA, 32'h3000_0044, 32'h7777_0000, ok);
      exp_q.push_back(mk(32'h0, 1'b0));
      n_run++;
      if (ok !== 1'b1 || wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h3000_0044 || wbm_sel_o !== 4'hA) begin
         n_fail++;
         $display("FAIL post_reset_start: ok=%b cyc=%b adr=%h sel=%h required 1/1/30000044/a",
                  ok, wbm_cyc_o, wbm_adr_o, wbm_sel_o);
      end
      run_bus(1, 32'h0, hi, stable);
      collect(got, dat, err);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(32'hX, 1'bX);
      exp_cnt++;
      n_run++;
      if (got !== 1'b1 || dat !== e.dat || err !== e.err || txn_count_o !== exp_cnt ||
          protocol_err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_rsp: got=%b dat=%h err=%b txn=%0d perr=%b required 1/%h/%b/%0d/1",
                  got, dat, err, txn_count_o, protocol_err_o, e.dat, e.err, exp_cnt);
      end
   endtask

   initial begin
      n_run = 0; n_fail = 0; exp_cnt = '0;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_sel_i = '0; req_adr_i = '0; req_dat_i = '0;
      rsp_ready_i = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_ack_at_timeout();
      test_back_to_back();
      test_reset_mid_bus();
      n_run++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: left=%0d required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 The block SHALL have one clock, clk_i; reset rst_ni SHALL be asynchronous and active-low.
REQ-002 Parameter WORD_SIZE, 32, data width of the request, response and bus data.
REQ-003 Parameter WHISBONE_ADR, 32, address width.
REQ-004 Parameter TIMEOUT_CYCLES, 16, maximum bus cycles spent waiting for ack before the transaction is aborted (legal values 2..255).
REQ-005 Parameter COUNTERSIZE, 32, width of the completed-transaction counter.
REQ-006 clk_i  in  1  system clock; every flop is rising-edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 req_valid_i  in  1  command valid; req_ready_o  out  1  command accepted when both are high.
REQ-009 req_we_i  in  1, req_sel_i  in  4, req_adr_i  in  WHISBONE_ADR, req_dat_i  in  WORD_SIZE: command fields.
REQ-010 rsp_valid_o  out  1, rsp_ready_i  in  1  response handshake; rsp_dat_o  out  WORD_SIZE  read data; rsp_err_o  out  1  timeout flag.
REQ-011 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1; wbm_sel_o  out  4; wbm_adr_o  out  WHISBONE_ADR; wbm_dat_o  out  WORD_SIZE: Wishbone classic master outputs.
REQ-012 wbm_dat_i  in  WORD_SIZE, wbm_ack_i  in  1: Wishbone slave returns.
REQ-013 busy_o  out  1  high outside IDLE; txn_count_o  out  COUNTERSIZE  acked transactions; protocol_err_o  out  1  sticky stray-ack flag.

Function
REQ-014 FSM states: IDLE, BUS, RESP; all Wishbone outputs and rsp_* outputs SHALL be registered.
REQ-015 IDLE: req_ready_o=1; on req_valid_i&req_ready_o all command fields are latched and the state becomes BUS next cycle.
REQ-016 Command accepted at edge N: wbm_cyc_o=wbm_stb_o=1 from cycle N+1, with wbm_adr_o/we/sel/dat held constant until the cycle ends.
REQ-017 wbm_dat_o SHALL equal the latched req_dat_i for writes and all-zero for reads; wbm_sel_o SHALL pass req_sel_i unchanged.
REQ-018 BUS: wbm_ack_i sampled high -> cyc/stb drop on the next cycle, rsp_valid_o=1, rsp_err_o=0, rsp_dat_o=wbm_dat_i for reads (0 for writes), state RESP.
REQ-019 BUS wait counter SHALL clear on entry and increment each BUS cycle without ack; on reaching TIMEOUT_CYCLES-1 without ack, cyc/stb drop, rsp_err_o=1, rsp_dat_o=0, state RESP.
REQ-020 Ack in the same cycle the timeout is reached SHALL win: normal completion, no error.
REQ-021 RESP: rsp_valid_o and rsp_* held stable until rsp_ready_i is high, then IDLE next cycle; req_ready_o=0 in BUS and RESP (one outstanding transaction).
REQ-022 txn_count_o SHALL increment by 1 per acked transaction (not on timeout), wrapping modulo 2^COUNTERSIZE.
REQ-023 wbm_ack_i high in IDLE or RESP SHALL be ignored for data and SHALL set protocol_err_o, cleared only by reset.

Reset
REQ-024 rst_ni low SHALL immediately force IDLE, all wbm_* outputs, rsp_valid_o, rsp_err_o, rsp_dat_o, busy_o, protocol_err_o and txn_count_o to 0, req_ready_o to 1 after release.
REQ-025 Reset mid-BUS SHALL abort the cycle with no response issued; the first command after release SHALL behave per REQ-016.

Structure
REQ-026 Shared package wb_initiator_pkg SHALL hold the FSM state enum and default widths (WORD_SIZE, WHISBONE_ADR, COUNTERSIZE).
REQ-027 The timeout counter SHALL be a sub-module wbm_timeout_timer (clear, enable, expired output); everything else is in wb_initiator.

Verification
REQ-028 Write adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, ack after 3 cycles -> wbm_we_o=1, fields stable, rsp_err_o=0, txn_count_o=1.
REQ-029 Read adr=0x3000_0008, slave acks with 0x1234_5678 -> rsp_dat_o=0x1234_5678 one cycle after ack, wbm_dat_o=0.
REQ-030 No ack -> cyc/stb high exactly TIMEOUT_CYCLES cycles (16), rsp_err_o=1, rsp_dat_o=0, txn_count_o unchanged.
REQ-031 Ack on cycle 16 coincident with timeout -> rsp_err_o=0, txn_count_o increments.
REQ-032 rsp_ready_i held low 5 cycles with new req_valid_i pending -> rsp stable, req_ready_o=0, second command starts only after response taken.
REQ-033 rst_ni asserted mid-BUS then stray ack in IDLE -> outputs zero during reset, no response, protocol_err_o=1 after stray ack.
